// File: rtl/spi_slave_burst_if.sv
// SPI pin and register-bus bundle for spi_slave_burst.
// The slave modport is the SPI block; master is the MCU pins plus register file side.
interface spi_slave_burst_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  sck;
  logic                  ncs;
  logic                  si;
  logic                  so;
  logic                  so_oe;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rw;
  logic                  frame_active;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_strobe;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;

  modport slave (
    input  sck, ncs, si, rd_data,
    output so, so_oe, addr, rw, frame_active, wr_data, wr_strobe, rd_req
  );

  modport master (
    output sck, ncs, si, rd_data,
    input  so, so_oe, addr, rw, frame_active, wr_data, wr_strobe, rd_req
  );
endinterface

// File: rtl/spi_slave_burst.sv
// Parametrised SPI slave with CPOL/CPHA selection, input synchronisers and
// auto-incrementing burst read/write frames, running in the clk domain.
module spi_slave_burst #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          BURST_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_burst_if.slave  bus
);

  localparam int unsigned HdrBits = ADDR_WIDTH + 1;
  localparam int unsigned MaxBits = (HdrBits > DATA_WIDTH) ? HdrBits : DATA_WIDTH;
  localparam int unsigned CntW    = $clog2(MaxBits);
  localparam bit          SampleOnRise = (CPOL == CPHA);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q, si_sync_q;
  logic                   sck_prev_q, ncs_prev_q;
  logic                   sck_s, ncs_s, si_s;
  logic                   sample_edge, shift_edge, ncs_fall;

  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [HdrBits-1:0]    hdr_q, hdr_d, hdr_next;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_next;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  so_q, so_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic                  rd_req_q, rd_req_d;
  logic                  rd_load_q;
  logic                  inc_q, inc_d;
  logic                  done_q, done_d;
  logic                  hdr_last, word_last;

  // ncs chain resets low so a select already held low after rst yields no falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= {SYNC_STAGES{CPOL}};
      ncs_sync_q <= '0;
      si_sync_q  <= '0;
      sck_prev_q <= CPOL;
      ncs_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
      si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], bus.si};
      sck_prev_q <= sck_s;
      ncs_prev_q <= ncs_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign si_s        = si_sync_q[SYNC_STAGES-1];
  assign sample_edge = SampleOnRise ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
  assign shift_edge  = SampleOnRise ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
  assign ncs_fall    = ncs_prev_q & ~ncs_s;
  assign hdr_last    = (bit_cnt_q == CntW'(ADDR_WIDTH));
  assign word_last   = (bit_cnt_q == CntW'(DATA_WIDTH - 1));
  assign hdr_next    = {hdr_q[HdrBits-2:0], si_s};
  assign rx_next     = {rx_q[DATA_WIDTH-2:0], si_s};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ncs_fall) state_d = StHeader;
      StHeader: begin
        if (ncs_s)                        state_d = StIdle;
        else if (sample_edge && hdr_last) state_d = StData;
      end
      StData:   if (ncs_s) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.frame_active = (state_q == StData);
    bus.so_oe        = (state_q == StData);
    bus.so           = (state_q == StData) & so_q;
    bus.addr         = addr_q;
    bus.rw           = rw_q;
    bus.wr_data      = wr_data_q;
    bus.wr_strobe    = wr_strobe_q;
    bus.rd_req       = rd_req_q;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hdr_d       = hdr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    wr_data_d   = wr_data_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    so_d        = so_q;
    done_d      = done_q;
    wr_strobe_d = 1'b0;
    rd_req_d    = 1'b0;
    inc_d       = 1'b0;

    if (inc_q)     addr_d = addr_q + ADDR_WIDTH'(1);
    if (rd_load_q) tx_d   = bus.rd_data;

    if (state_q == StHeader && sample_edge) begin
      hdr_d     = hdr_next;
      bit_cnt_d = bit_cnt_q + CntW'(1);
      if (hdr_last) begin
        bit_cnt_d = '0;
        rw_d      = hdr_next[HdrBits-1];
        addr_d    = hdr_next[ADDR_WIDTH-1:0];
        rd_req_d  = hdr_next[HdrBits-1];
      end
    end

    if (state_q == StData && !done_q) begin
      if (sample_edge) begin
        bit_cnt_d = word_last ? '0 : bit_cnt_q + CntW'(1);
        if (!rw_q) rx_d = rx_next;
        if (word_last) begin
          done_d = !BURST_EN;
          if (rw_q) begin
            if (BURST_EN) begin
              addr_d   = addr_q + ADDR_WIDTH'(1);
              rd_req_d = 1'b1;
            end
          end else begin
            wr_data_d   = rx_next;
            wr_strobe_d = 1'b1;
            inc_d       = BURST_EN;
            rx_d        = '0;
          end
        end
      end
      if (shift_edge && rw_q) begin
        so_d = tx_q[DATA_WIDTH-1];
        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    if (state_q == StData && done_q && shift_edge) so_d = 1'b0;

    if (state_q == StIdle && ncs_fall) begin
      addr_d = '0;
      rw_d   = 1'b0;
    end

    // A word completed on the same clk ncs rose still strobes with its data.
    if (state_q == StIdle || ncs_s) begin
      bit_cnt_d = '0;
      hdr_d     = '0;
      rx_d      = '0;
      tx_d      = '0;
      so_d      = 1'b0;
      done_d    = 1'b0;
      rd_req_d  = 1'b0;
      inc_d     = 1'b0;
      if (!wr_strobe_d) wr_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wr_data_q   <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      so_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_load_q   <= 1'b0;
      inc_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wr_data_q   <= wr_data_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      so_q        <= so_d;
      wr_strobe_q <= wr_strobe_d;
      rd_req_q    <= rd_req_d;
      rd_load_q   <= rd_req_q;
      inc_q       <= inc_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: five instances (modes 0-3 with bursts, mode 0 single-word)
// driven by one bit-banged SPI master; bus events are checked against an expected queue.
module tb_spi_slave_burst;

  localparam int NDut = 5;
  localparam int Half = 80;

  typedef struct {
    bit          rd;
    int unsigned dut;
    logic [6:0]  addr;
    logic [23:0] data;
  } ev_t;

  typedef struct {
    int unsigned dut;
    logic [7:0]  hdr;
    logic [71:0] payload;
    int unsigned nbits;
    int unsigned n_ev;
    bit          ev_rd;
    logic [20:0] ev_addr;
    logic [71:0] ev_data;
    logic [71:0] exp_rd;
    logic [6:0]  exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic sck_line;
  logic si_line;
  logic [NDut-1:0] ncs_v;
  logic [23:0] rd_mem [128];

  logic [NDut-1:0] so_v, oe_v, fa_v, rw_v, ws_v, rr_v;
  logic [6:0]  addr_v [NDut];
  logic [23:0] wd_v [NDut];

  int checks = 0;
  int errors = 0;
  ev_t exp_q [$];
  ev_t mon_ev;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    spi_slave_burst_if bus ();
    spi_slave_burst #(
      .CPOL    (g == 2 || g == 3),
      .CPHA    (g == 1 || g == 3),
      .BURST_EN(g != 4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.sck     = sck_line;
    assign bus.ncs     = ncs_v[g];
    assign bus.si      = si_line;
    assign bus.rd_data = rd_mem[bus.addr];
    assign so_v[g]     = bus.so;
    assign oe_v[g]     = bus.so_oe;
    assign fa_v[g]     = bus.frame_active;
    assign rw_v[g]     = bus.rw;
    assign ws_v[g]     = bus.wr_strobe;
    assign rr_v[g]     = bus.rd_req;
    assign addr_v[g]   = bus.addr;
    assign wd_v[g]     = bus.wr_data;
  end

  function automatic logic cpol_of(input int unsigned d);
    return (d == 2 || d == 3);
  endfunction

  function automatic logic cpha_of(input int unsigned d);
    return (d == 1 || d == 3);
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One SCK period; master samples MISO just before its sampling edge.
  task automatic spi_bit(input int unsigned d, input logic mosi, output logic miso);
    if (!cpha_of(d)) begin
      si_line = mosi;
      #Half;
      miso = so_v[d];
      sck_line = ~sck_line;
      #Half;
      sck_line = ~sck_line;
    end else begin
      sck_line = ~sck_line;
      si_line = mosi;
      #Half;
      miso = so_v[d];
      sck_line = ~sck_line;
      #Half;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NDut; i++) begin
      if (ws_v[i] || rr_v[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event dut=%0d actual rd_req=%0b addr=%h data=%h required none",
                   i, rr_v[i], addr_v[i], wd_v[i]);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_ev.dut != i || mon_ev.rd != rr_v[i] || mon_ev.addr !== addr_v[i] ||
              (!mon_ev.rd && mon_ev.data !== wd_v[i])) begin
            errors++;
            $display("FAIL bus_event actual dut=%0d rd=%0b addr=%h data=%h required dut=%0d rd=%0b addr=%h data=%h",
                     i, rr_v[i], addr_v[i], wd_v[i], mon_ev.dut, mon_ev.rd, mon_ev.addr,
                     mon_ev.data);
          end
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    logic [71:0] capt;
    logic [71:0] mask;
    logic        b;
    ev_t         e;
    int unsigned d;
    d = v.dut;
    sck_line = cpol_of(d);
    si_line  = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < int'(v.n_ev); i++) begin
      e.rd   = v.ev_rd;
      e.dut  = d;
      e.addr = v.ev_addr[20 - 7*i -: 7];
      e.data = v.ev_data[71 - 24*i -: 24];
      exp_q.push_back(e);
    end
    ncs_v[d] = 1'b0;
    #Half;
    for (int i = 0; i < 8; i++) spi_bit(d, v.hdr[7-i], b);
    check($sformatf("v%0d_hdr_oe_fa_rw", idx), {oe_v[d], fa_v[d], rw_v[d]},
          {1'b1, 1'b1, v.hdr[7]});
    capt = '0;
    for (int i = 0; i < int'(v.nbits); i++) begin
      spi_bit(d, v.hdr[7] ? 1'b0 : v.payload[71-i], b);
      capt[71-i] = b;
    end
    ncs_v[d] = 1'b1;
    repeat (10) @(negedge clk);
    check($sformatf("v%0d_end_oe_fa_so", idx), {oe_v[d], fa_v[d], so_v[d]}, 72'h0);
    check($sformatf("v%0d_end_addr", idx), addr_v[d], v.exp_addr);
    if (v.hdr[7]) begin
      mask = ~72'h0 << (72 - v.nbits);
      check($sformatf("v%0d_rd_words", idx), capt & mask, v.exp_rd & mask);
    end
    check($sformatf("v%0d_events_left", idx), exp_q.size(), 72'h0);
  endtask

  localparam logic [71:0] RdExp = {24'h123456, 24'h654321, 24'h000000};

  vec_t vecs [10];
  vec_t rec;

  initial begin
    logic b;
    for (int i = 0; i < 128; i++) rd_mem[i] = 24'h0;
    rd_mem[5] = 24'h123456;
    rd_mem[6] = 24'h654321;
    rd_mem[7] = 24'hC0FFEE;

    // dut, hdr, payload, nbits, n_ev, ev_rd, ev_addr, ev_data, exp_rd, exp_addr
    vecs[0] = '{0, 8'h12, {24'hABCDEF, 48'h0}, 24, 1, 1'b0, {7'h12, 14'h0},
                {24'hABCDEF, 48'h0}, 72'h0, 7'h13};
    vecs[1] = '{0, 8'h7E, {24'h000001, 24'h000002, 24'h000003}, 72, 3, 1'b0,
                {7'h7E, 7'h7F, 7'h00}, {24'h000001, 24'h000002, 24'h000003}, 72'h0, 7'h01};
    vecs[2] = '{1, 8'h85, 72'h0, 48, 3, 1'b1, {7'h05, 7'h06, 7'h07}, 72'h0, RdExp, 7'h07};
    vecs[3] = '{2, 8'h85, 72'h0, 48, 3, 1'b1, {7'h05, 7'h06, 7'h07}, 72'h0, RdExp, 7'h07};
    vecs[4] = '{3, 8'h85, 72'h0, 48, 3, 1'b1, {7'h05, 7'h06, 7'h07}, 72'h0, RdExp, 7'h07};
    vecs[5] = '{0, 8'h85, 72'h0, 48, 3, 1'b1, {7'h05, 7'h06, 7'h07}, 72'h0, RdExp, 7'h07};
    vecs[6] = '{0, 8'h30, {24'hFFFFFF, 48'h0}, 10, 0, 1'b0, 21'h0, 72'h0, 72'h0, 7'h30};
    vecs[7] = '{0, 8'h20, {24'h5A5A5A, 48'h0}, 24, 1, 1'b0, {7'h20, 14'h0},
                {24'h5A5A5A, 48'h0}, 72'h0, 7'h21};
    vecs[8] = '{4, 8'h03, {24'h111111, 24'h222222, 24'h0}, 48, 1, 1'b0, {7'h03, 14'h0},
                {24'h111111, 48'h0}, 72'h0, 7'h03};
    vecs[9] = '{4, 8'h85, 72'h0, 48, 1, 1'b1, {7'h05, 14'h0}, 72'h0,
                {24'h123456, 48'h0}, 7'h05};

    rst      = 1'b1;
    sck_line = 1'b0;
    si_line  = 1'b0;
    ncs_v    = '1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < NDut; i++)
      check($sformatf("reset_outputs_dut%0d", i),
            {so_v[i], oe_v[i], fa_v[i], rw_v[i], ws_v[i], rr_v[i], addr_v[i], wd_v[i]}, 72'h0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // rst in the middle of a header with ncs held low: frame must be ignored.
    sck_line = 1'b0;
    repeat (10) @(negedge clk);
    ncs_v[0] = 1'b0;
    #Half;
    for (int i = 0; i < 4; i++) spi_bit(0, i[0], b);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_outputs", {oe_v[0], fa_v[0], rw_v[0], so_v[0], addr_v[0], wd_v[0]}, 72'h0);
    for (int i = 0; i < 28; i++) spi_bit(0, 1'b1, b);
    check("rst_ignored_frame", {fa_v[0], oe_v[0], addr_v[0]}, 72'h0);
    ncs_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_events", exp_q.size(), 72'h0);

    rec = '{0, 8'h44, {24'h0F0F0F, 48'h0}, 24, 1, 1'b0, {7'h44, 14'h0},
            {24'h0F0F0F, 48'h0}, 72'h0, 7'h45};
    run_vec(10, rec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
Parametrised SPI slave, successor to the fixed mode-0 soft SPI slave. Supports all four CPOL/CPHA modes, configurable address and data widths, and input synchronisers. Supports burst frames: after one [R/W, addr] header, consecutive data words auto-increment the address. Sits between the MCU SPI pins and the register file / DSP control bus, running entirely in the FPGA clock domain.

Parameters:
ADDR_WIDTH, 7, address field width in bits (≥2)
DATA_WIDTH, 24, data word width in bits (≥2)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, synchroniser flops on sck/ncs/si (≥2)
BURST_EN, 1, 1 = address auto-increment per word; 0 = single word per frame

Ports:
clk  in  1  system clock; must be ≥8× SCK frequency
rst  in  1  synchronous, active-high reset
sck  in  1  SPI clock (asynchronous)
ncs  in  1  chip select, active low (asynchronous)
si  in  1  MOSI (asynchronous)
so  out  1  MISO data
so_oe  out  1  MISO output enable (=1 while frame active)
addr  out  ADDR_WIDTH  current word address
rw  out  1  1 = read frame, 0 = write frame
frame_active  out  1  header complete and ncs still low
wr_data  out  DATA_WIDTH  last received write word
wr_strobe  out  1  one-clk pulse: wr_data valid for addr
rd_req  out  1  one-clk pulse: request rd_data for addr
rd_data  in  DATA_WIDTH  read data; must be valid the clk after rd_req

Behaviour:
- Inputs pass through SYNC_STAGES flops. Edge detection uses the last two synchronised sck samples. Sample edge = rising when CPOL==CPHA, else falling. Shift edge = the opposite edge.
- Frame format, MSB first: rw (1 bit), addr (ADDR_WIDTH bits), then N×DATA_WIDTH data words.
- States: IDLE, HEADER, DATA.
  - IDLE→HEADER when synced ncs goes low.
  - HEADER→DATA on the sample edge that captures the last address bit.
  - Any state→IDLE on synced ncs high or rst.
- Reset, and also ncs high: all outputs 0; bit counters and shift registers cleared. addr/rw hold their last value only until the next frame starts, and are cleared on rst.
- HEADER: so=0. On the final header bit: addr and rw are loaded and frame_active=1 on the next clk. If rw=1, rd_req pulses in that same cycle.
- Read path:
  - rd_data is loaded into the TX shift register the clk after rd_req.
  - MSB is driven on so at the next shift edge; one bit per shift edge thereafter.
  - On the sample edge of the last bit of word k: if BURST_EN, addr←addr+1 and rd_req pulses for word k+1. The load-then-shift timing is the same as for the first word.
  - Incoming si bits are ignored in read frames.
- Write path:
  - si is shifted in on sample edges.
  - On the DATA_WIDTH-th bit of a word: wr_data latched and wr_strobe=1 for exactly one clk, with addr = that word's address.
  - The following clk: addr←addr+1 if BURST_EN.
- Address wraps modulo 2^ADDR_WIDTH (e.g. 0x7F→0x00 for ADDR_WIDTH=7).
- BURST_EN=0: after the first word, further SCK edges are ignored (no strobes or rd_req); so=0 until ncs high.
- Partial word at ncs rise: discarded; no wr_strobe; addr not incremented.
- ncs rising while wr_strobe is pending in the same clk: the strobe still fires (the word completed on a prior sample edge).
- rst mid-frame: immediate return to IDLE. The current frame is ignored until ncs is deasserted and reasserted.
- SCK edges while ncs is high are ignored.

Test Plan:
- Mode 0 write: rw=0, addr=0x12, data 0xABCDEF → single wr_strobe with addr=0x12, wr_data=0xABCDEF; so_oe=1 during frame, 0 after.
- Burst write, mode 0: addr=0x7E, 3 words 0x000001/0x000002/0x000003 → strobes at addr 0x7E, 0x7F, 0x00 with matching data.
- Burst read, modes 1/2/3: addr=0x05, rd_data = 0x123456 then 0x654321 → rd_req at addr 0x05 then 0x06; master samples 0x123456, 0x654321 MSB-first on correct edges.
- Abort: write frame, ncs rises after 10 data bits → no wr_strobe, addr unchanged; next full frame to addr 0x20 strobes normally.
- BURST_EN=0: write 2 words at addr 0x03 → exactly one strobe (addr 0x03, first word); read frame → one rd_req, so=0 during second word.
- rst asserted mid-header, ncs held low → all outputs 0, no strobe or rd_req until ncs toggles high→low and a new frame completes.
